// File: rtl/qea_state_reader.sv
// Readout engine for the QEA state RAM: sweeps every row and streams one {re, im} amplitude per beat.
// Optional QEA_RD_PROB_EN adds o_amp_prob = saturated (re^2 + im^2) >>> NUM_FRAC_BIT per beat.
`timescale 1ns/1ps
module qea_state_reader #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = DATA_WIDTH*2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    output logic                                     o_state_ena,
    output logic                                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
    output logic                                     o_amp_valid,
    input  logic                                     i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0]              o_amp_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_idx,
    output logic                                     o_amp_last,
    output logic                                     o_busy,
    output logic                                     o_done
`ifdef QEA_RD_PROB_EN
    ,
    output logic [DATA_WIDTH-1:0]                    o_amp_prob
`endif
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int ROW_W = STATE_ADDR_WIDTH + 1;
    localparam logic [PE_NUM_WIDTH-1:0] LANE_LAST = PE_NUM_WIDTH'(PE_NUM - 1);
    localparam logic [PE_NUM_WIDTH-1:0] LANE_ONE  = PE_NUM_WIDTH'(1);
    localparam logic [ROW_W-1:0]        ROW_ONE   = ROW_W'(1);

    logic [2:0]                           state;
    logic [ROW_W-1:0]                     row_cnt;
    logic [ROW_W-1:0]                     last_row;
    logic [PE_NUM_WIDTH-1:0]              lane_cnt;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   cap_p1;
    logic [STATE_DATA_WIDTH-1:0]          lane_data [PE_NUM];
    logic                                 vld_p1;
    logic                                 row_at_end;
    logic                                 lane_at_end;

    // Last row index = ROWS-1, clamped to one row below and to full RAM depth above.
    function automatic logic [ROW_W-1:0] calc_last_row(input logic [MAX_QBIT_WIDTH-1:0] qb);
        int               sh;
        logic [ROW_W-1:0] one_v;
        one_v = ROW_ONE;
        sh = int'(qb) - PE_NUM_WIDTH;
        if (sh <= 0)
            return '0;
        if (sh > STATE_ADDR_WIDTH)
            sh = STATE_ADDR_WIDTH;
        return (one_v << sh) - one_v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_prob(input logic signed [2*DATA_WIDTH:0] s);
        logic signed [2*DATA_WIDTH:0] q;
        q = s >>> NUM_FRAC_BIT;
        if (|q[2*DATA_WIDTH:DATA_WIDTH])
            return '1;
        return q[DATA_WIDTH-1:0];
    endfunction

    for (genvar p = 0; p < PE_NUM; p++) begin : g_lane
        assign lane_data[p] = cap_p1[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
    end

    assign vld_p1      = (state == S_SEND);
    assign row_at_end  = (row_cnt == last_row);
    assign lane_at_end = (lane_cnt == LANE_LAST);

    assign o_state_ena   = (state == S_RD);
    assign o_state_wea   = 1'b0;
    assign o_state_addra = o_state_ena ? row_cnt[STATE_ADDR_WIDTH-1:0] : '0;
    assign o_amp_valid   = vld_p1;
    assign o_amp_data    = lane_data[lane_cnt];
    assign o_amp_idx     = {row_cnt[STATE_ADDR_WIDTH-1:0], lane_cnt};
    assign o_amp_last    = vld_p1 && row_at_end && lane_at_end;
    assign o_busy        = (state == S_RD) || (state == S_CAP) || (state == S_SEND);
    assign o_done        = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row_cnt  <= '0;
            last_row <= '0;
            lane_cnt <= '0;
            cap_p1   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        last_row <= calc_last_row(i_qbit_num);
                        row_cnt  <= '0;
                        lane_cnt <= '0;
                        state    <= S_RD;
                    end
                end
                S_RD:  state <= S_CAP;
                // Row data arrives one cycle after the enable, i.e. during CAP.
                S_CAP: begin
                    cap_p1   <= i_state_dout;
                    lane_cnt <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (i_amp_ready) begin
                        lane_cnt <= lane_cnt + LANE_ONE;
                        if (lane_at_end) begin
                            if (row_at_end) begin
                                state <= S_DONE;
                            end else begin
                                row_cnt <= row_cnt + ROW_ONE;
                                state   <= S_RD;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef QEA_RD_PROB_EN
    logic signed [DATA_WIDTH-1:0]   amp_re;
    logic signed [DATA_WIDTH-1:0]   amp_im;
    logic signed [2*DATA_WIDTH-1:0] sq_re;
    logic signed [2*DATA_WIDTH-1:0] sq_im;
    logic signed [2*DATA_WIDTH:0]   pwr_sum;

    assign amp_re     = o_amp_data[STATE_DATA_WIDTH-1 -: DATA_WIDTH];
    assign amp_im     = o_amp_data[DATA_WIDTH-1:0];
    assign sq_re      = (2*DATA_WIDTH)'(amp_re) * (2*DATA_WIDTH)'(amp_re);
    assign sq_im      = (2*DATA_WIDTH)'(amp_im) * (2*DATA_WIDTH)'(amp_im);
    assign pwr_sum    = (2*DATA_WIDTH+1)'(sq_re) + (2*DATA_WIDTH+1)'(sq_im);
    assign o_amp_prob = sat_prob(pwr_sum);
`endif

endmodule

// File: tb/tb_qea_state_reader.sv
// Scoreboard bench for qea_state_reader: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_qea_state_reader;
    localparam int NROW = 512;

    typedef struct packed {
        logic [63:0] data;
        logic [17:0] idx;
        logic        last;
        logic [31:0] prob;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [5:0]   i_qbit_num = '0;
    logic         o_state_ena;
    logic         o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] i_state_dout = '0;
    logic         o_amp_valid;
    logic         i_amp_ready = 1'b1;
    logic [63:0]  o_amp_data;
    logic [17:0]  o_amp_idx;
    logic         o_amp_last;
    logic         o_busy;
    logic         o_done;
`ifdef QEA_RD_PROB_EN
    logic [31:0]  o_amp_prob;
`endif

    qea_state_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_qbit_num    (i_qbit_num),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .i_state_dout  (i_state_dout),
        .o_amp_valid   (o_amp_valid),
        .i_amp_ready   (i_amp_ready),
        .o_amp_data    (o_amp_data),
        .o_amp_idx     (o_amp_idx),
        .o_amp_last    (o_amp_last),
        .o_busy        (o_busy),
        .o_done        (o_done)
`ifdef QEA_RD_PROB_EN
        ,
        .o_amp_prob    (o_amp_prob)
`endif
    );

    logic [63:0] lv [0:NROW-1][0:3];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          done_count = 0;
    int          ena_count = 0;
    int          exp_row = 0;
    int          ready_mode = 0;
    bit          wea_seen = 1'b0;

    initial forever #5 clk = ~clk;

    // State RAM model: one-cycle read latency, lane 0 in the MSB slice.
    initial begin
        logic        ram_en;
        logic [15:0] ram_a;
        forever begin
            @(negedge clk);
            ram_en = o_state_ena;
            ram_a  = o_state_addra;
            @(posedge clk);
            if (ram_en)
                i_state_dout <= {lv[ram_a[8:0]][0], lv[ram_a[8:0]][1], lv[ram_a[8:0]][2], lv[ram_a[8:0]][3]};
        end
    end

    initial begin
        logic [3:0] pat;
        int         rc;
        pat = 4'b1001;
        rc  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       i_amp_ready = pat[3 - (rc % 4)];
                2:       i_amp_ready = 1'($urandom_range(0, 1));
                default: i_amp_ready = 1'b1;
            endcase
            rc++;
        end
    end

    function automatic logic [31:0] prob_model(input logic [63:0] a);
        logic signed [31:0] re, im;
        logic [64:0]        s;
        re = a[63:32];
        im = a[31:0];
        s  = 65'(64'(longint'(re) * longint'(re))) + 65'(64'(longint'(im) * longint'(im)));
        s  = s >> 30;
        return (s > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    initial begin
        exp_t        e;
        bit          prev_stall, prev_last_hs;
        logic [82:0] held;
        prev_stall = 0;
        prev_last_hs = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (o_state_wea) wea_seen = 1'b1;
            if (!rst_n) begin
                prev_stall = 0;
                prev_last_hs = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!o_amp_valid || {o_amp_data, o_amp_idx, o_amp_last} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b beat=%h expected valid=1 beat=%h",
                                 o_amp_valid, {o_amp_data, o_amp_idx, o_amp_last}, held);
                    end
                end
                if (o_done) begin
                    checks++;
                    done_count++;
                    if (!prev_last_hs) begin
                        errors++;
                        $display("FAIL done_timing: got done without last handshake one cycle earlier, expected done right after last beat");
                    end
                end
                if (o_state_ena) begin
                    chk("ram_addr", 64'(o_state_addra), 64'(exp_row));
                    exp_row++;
                    ena_count++;
                end
                if (o_amp_valid && i_amp_ready) begin
                    hs_count++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got idx=%0d data=%h expected no beat", o_amp_idx, o_amp_data);
                    end else begin
                        e = sb.pop_front();
                        if (o_amp_data !== e.data || o_amp_idx !== e.idx || o_amp_last !== e.last) begin
                            errors++;
                            $display("FAIL beat: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                                     o_amp_data, o_amp_idx, o_amp_last, e.data, e.idx, e.last);
                        end
`ifdef QEA_RD_PROB_EN
                        chk("amp_prob", 64'(o_amp_prob), 64'(e.prob));
`endif
                    end
                end
                prev_last_hs = o_amp_valid && i_amp_ready && o_amp_last;
                prev_stall   = o_amp_valid && !i_amp_ready;
                held         = {o_amp_data, o_amp_idx, o_amp_last};
            end
        end
    end

    task automatic clear_lv();
        for (int r = 0; r < NROW; r++)
            for (int p = 0; p < 4; p++)
                lv[r][p] = '0;
    endtask

    task automatic start_sweep(input logic [5:0] qb, input int nrows, input int rmode);
        exp_t e;
        int   cyc;
        for (int r = 0; r < nrows; r++) begin
            for (int p = 0; p < 4; p++) begin
                e.data = lv[r][p];
                e.idx  = {16'(r), 2'(p)};
                e.last = (r == nrows - 1) && (p == 3);
                e.prob = prob_model(lv[r][p]);
                sb.push_back(e);
            end
        end
        ena_count  = 0;
        exp_row    = 0;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        i_qbit_num = qb;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
        cyc = 1;
        while (!o_amp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("first_valid_latency", 64'(cyc), 64'd3);
    endtask

    task automatic finish_sweep(input int nrows, input int done_base);
        int cyc;
        cyc = 0;
        while (done_count == done_base && cyc < nrows * 24 + 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", 64'(done_count - done_base), 64'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(o_done), 64'd0);
        chk("busy_after_done", 64'(o_busy), 64'd0);
        chk("ena_pulses", 64'(ena_count), 64'(nrows));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int db, hb, cyc;
        clear_lv();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_amp_valid), 64'd0);
        chk("rst_ena", 64'(o_state_ena), 64'd0);
        chk("rst_busy_done", 64'({o_busy, o_done}), 64'd0);
        chk("rst_data_idx", {o_amp_data[45:0], o_amp_idx}, 64'd0);
        rst_n = 1'b1;

        // 11 qubits: 512 rows, single non-zero amplitude at idx 0.
        lv[0][0] = 64'h40000000_00000000;
        db = done_count;
        start_sweep(6'd11, 512, 0);
        finish_sweep(512, db);

        // 2 qubits: one row, distinct lanes check the MSB-first lane order.
        lv[0][1] = 64'h00000001_FFFFFFFF;
        lv[0][2] = 64'hA5A5A5A5_5A5A5A5A;
        lv[0][3] = 64'h7FFFFFFF_80000000;
        db = done_count;
        start_sweep(6'd2, 1, 0);
        finish_sweep(1, db);

        // 0 qubits still reads one row.
        db = done_count;
        start_sweep(6'd0, 1, 0);
        finish_sweep(1, db);

        // 3 qubits: two rows, ready pattern 1,0,0,1.
        lv[0][0] = 64'h11111111_22222222;
        lv[0][1] = 64'h33333333_44444444;
        lv[0][2] = 64'h55555555_66666666;
        lv[0][3] = 64'h77777777_88888888;
        lv[1][0] = 64'h40000000_00000000;
        lv[1][1] = 64'h20000000_20000000;
        lv[1][2] = 64'h80000000_7FFFFFFF;
        lv[1][3] = 64'hFFFFFFFF_00000001;
        db = done_count;
        start_sweep(6'd3, 2, 1);
        finish_sweep(2, db);

        // 4 qubits: four rows, random ready, second start ignored while busy.
        for (int r = 0; r < 4; r++)
            for (int p = 0; p < 4; p++)
                lv[r][p] = {32'(r * 16 + p + 1), 32'h0BAD_0000 + 32'(r * 4 + p)};
        db = done_count;
        start_sweep(6'd4, 4, 2);
        @(posedge clk);
        #1;
        i_qbit_num = 6'd11;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        finish_sweep(4, db);

        // Reset after the fifth beat of an 11-qubit sweep, then restart.
        clear_lv();
        lv[0][0] = 64'h40000000_00000000;
        lv[0][3] = 64'h00000000_12345678;
        db = done_count;
        hb = hs_count;
        start_sweep(6'd11, 512, 0);
        cyc = 0;
        while (hs_count < hb + 5 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("beats_before_reset", 64'(hs_count - hb), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_last", 64'({o_amp_valid, o_amp_last}), 64'd0);
        chk("midrst_ena_addr", 64'({o_state_ena, o_state_addra}), 64'd0);
        chk("midrst_busy_done", 64'({o_busy, o_done}), 64'd0);
        chk("midrst_data_idx", {o_amp_data[45:0], o_amp_idx}, 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("no_done_after_abort", 64'(done_count), 64'(db));
        db = done_count;
        start_sweep(6'd2, 1, 0);
        finish_sweep(1, db);

        chk("wea_never_high", 64'(wea_seen), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
